// File: rtl/efuse_read.sv
// efuse_read: reads one NW-bit word of the 256-bit eFuse array bit by bit through the macro read port.
// Latency: NW*(T+2) cycles from the accepting edge to the read_done pulse (T = rg_efuse_trd, 0 counts as 1).
// Backpressure: none queued; read_start is only sampled in IDLE, and busy_read tells the requester to hold off.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   rg_efuse_trd, read_sel    strobe width and word select, both latched when a request is accepted
//   read_start                request level, sampled every cycle while idle
//   efuse_dout_i              macro sense output for the addressed bit
//   read_data, read_done      last completed word and its one-cycle update pulse
//   busy_read                 read in progress
//   efuse_rden_o, efuse_aen_o, efuse_addr_o   macro read enable, sense strobe and bit address
module efuse_read #(
  parameter int NW   = 64,
  parameter int WSEL = 256 / NW,
  localparam int SW  = (WSEL > 1) ? $clog2(WSEL) : 1,
  localparam int IW  = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    rg_efuse_trd,
  input  logic [SW-1:0] read_sel,
  input  logic          read_start,
  input  logic          efuse_dout_i,
  output logic [NW-1:0] read_data,
  output logic          read_done,
  output logic          busy_read,
  output logic          efuse_rden_o,
  output logic          efuse_aen_o,
  output logic [7:0]    efuse_addr_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_SAMPLE
  } state_t;

  state_t        r_state;
  logic [3:0]    r_trd;
  logic [3:0]    r_cnt;
  logic [IW-1:0] r_idx;
  logic [NW-1:0] r_shadow;

  logic [7:0]    w_base;
  logic [NW-1:0] w_shadow_nxt;
  logic          w_last;

  // Base address of the selected word; legal selects never exceed 255 - (NW-1).
  assign w_base = 8'(read_sel) * 8'(NW);
  assign w_last = (r_idx == IW'(NW - 1));

  // Shadow with the current bit merged in, so the final copy includes the last sampled bit.
  always_comb begin
    w_shadow_nxt        = r_shadow;
    w_shadow_nxt[r_idx] = efuse_dout_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_trd        <= 4'd1;
      r_cnt        <= 4'd0;
      r_idx        <= '0;
      r_shadow     <= '0;
      read_data    <= '0;
      read_done    <= 1'b0;
      busy_read    <= 1'b0;
      efuse_rden_o <= 1'b0;
      efuse_aen_o  <= 1'b0;
      efuse_addr_o <= 8'd0;
    end else begin
      read_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (read_start) begin
            r_trd        <= (rg_efuse_trd == 4'd0) ? 4'd1 : rg_efuse_trd;
            r_idx        <= '0;
            busy_read    <= 1'b1;
            efuse_rden_o <= 1'b1;
            efuse_addr_o <= w_base;
            r_state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          efuse_aen_o <= 1'b1;
          // First strobe cycle is already under way when the counter reads 1.
          r_cnt       <= 4'd1;
          r_state     <= S_STROBE;
        end
        S_STROBE: begin
          if (r_cnt == r_trd) begin
            efuse_aen_o <= 1'b0;
            r_state     <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          r_shadow <= w_shadow_nxt;
          if (w_last) begin
            read_data    <= w_shadow_nxt;
            read_done    <= 1'b1;
            busy_read    <= 1'b0;
            efuse_rden_o <= 1'b0;
            efuse_addr_o <= 8'd0;
            r_state      <= S_IDLE;
          end else begin
            // rden stays high between bits; only the address advances.
            r_idx        <= r_idx + IW'(1);
            efuse_addr_o <= efuse_addr_o + 8'd1;
            r_state      <= S_SETUP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
